// File: rtl/hv_bit_collector.sv
// Steps the feature bundler through every hypervector dimension, packs the thresholded bits
// into WORD_W-bit words and streams them out through a 2-entry show-ahead buffer.
module hv_bit_collector #(
  parameter int HV_DIM = 1024,
  parameter int WORD_W = 32,
  parameter int DIM_W  = $clog2(HV_DIM),
  parameter int CNT_W  = $clog2(HV_DIM + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [DIM_W-1:0]  dim_idx,
  output logic              bundling_features,
  input  logic              thresholded_bit,
  output logic [WORD_W-1:0] hv_word,
  output logic              hv_word_valid,
  output logic              hv_word_last,
  input  logic              hv_word_ready,
  output logic [CNT_W-1:0]  ones_count,
  output logic              busy,
  output logic              done
);

  localparam int BP_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [BP_W-1:0]  BP_LAST  = BP_W'(WORD_W - 1);
  localparam logic [DIM_W-1:0] DIM_LAST = DIM_W'(HV_DIM - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e            state_q;
  logic [DIM_W-1:0]  dim_q;
  logic [BP_W-1:0]   bitpos_q;
  logic [WORD_W-1:0] word_q;
  logic [CNT_W-1:0]  run_cnt_q;
  logic [CNT_W-1:0]  ones_q;
  logic              done_q;

  logic [WORD_W-1:0] fifo_data_q [2];
  logic              fifo_last_q [2];
  logic              rd_ptr_q;
  logic              wr_ptr_q;
  logic [1:0]        fifo_cnt_q;

  logic [WORD_W-1:0] word_d;
  logic              en;
  logic              push;
  logic              pop;
  logic              last_dim;
  logic              flush;

  function automatic logic [WORD_W-1:0] insert_bit(input logic [WORD_W-1:0] w,
                                                   input logic [BP_W-1:0]   pos,
                                                   input logic              b);
    logic [WORD_W-1:0] r;
    r      = w;
    r[pos] = b;
    return r;
  endfunction

  // The only stall: the word-completing bit cannot be taken while both buffer slots are full.
  assign bundling_features = (state_q == S_RUN) &&
                             !((bitpos_q == BP_LAST) && (fifo_cnt_q == 2'd2));

  always_comb begin
    word_d   = insert_bit(word_q, bitpos_q, thresholded_bit);
    en       = bundling_features;
    last_dim = (dim_q == DIM_LAST);
    push     = en && (bitpos_q == BP_LAST);
    pop      = hv_word_valid && hv_word_ready;
    flush    = abort && (state_q != S_IDLE);
  end

  assign dim_idx       = dim_q;
  assign hv_word       = fifo_data_q[rd_ptr_q];
  assign hv_word_last  = fifo_last_q[rd_ptr_q];
  assign hv_word_valid = (fifo_cnt_q != 2'd0);
  assign ones_count    = ones_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      dim_q          <= '0;
      bitpos_q       <= '0;
      word_q         <= '0;
      run_cnt_q      <= '0;
      ones_q         <= '0;
      done_q         <= 1'b0;
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_last_q[0] <= 1'b0;
      fifo_last_q[1] <= 1'b0;
      rd_ptr_q       <= 1'b0;
      wr_ptr_q       <= 1'b0;
      fifo_cnt_q     <= 2'd0;
    end else begin
      done_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            dim_q     <= '0;
            bitpos_q  <= '0;
            word_q    <= '0;
            run_cnt_q <= '0;
            state_q   <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            state_q <= S_IDLE;
          end else if (en) begin
            word_q    <= word_d;
            run_cnt_q <= run_cnt_q + CNT_W'(thresholded_bit);
            bitpos_q  <= (bitpos_q == BP_LAST) ? '0 : bitpos_q + 1'b1;
            if (last_dim) begin
              dim_q   <= '0;
              state_q <= S_DRAIN;
            end else begin
              dim_q <= dim_q + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (abort) begin
            state_q <= S_IDLE;
          end else if (pop && hv_word_last) begin
            done_q  <= 1'b1;
            ones_q  <= run_cnt_q;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // Output buffer: push is never attempted when full because the stall above prevents it.
      if (flush) begin
        rd_ptr_q   <= 1'b0;
        wr_ptr_q   <= 1'b0;
        fifo_cnt_q <= 2'd0;
      end else begin
        if (push) begin
          fifo_data_q[wr_ptr_q] <= word_d;
          fifo_last_q[wr_ptr_q] <= last_dim;
          wr_ptr_q              <= ~wr_ptr_q;
        end
        if (pop) begin
          rd_ptr_q <= ~rd_ptr_q;
        end
        case ({push, pop})
          2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
          2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
          default: fifo_cnt_q <= fifo_cnt_q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hv_bit_collector.sv
// Directed bench for hv_bit_collector: a 64-dim instance for timing/abort/reset cases and a
// 128-dim instance for backpressure and randomised-ready packing.
module tb_hv_bit_collector;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        start64, abort64, bf64, tb64, v64, l64, rdy64, busy64, done64;
  logic [5:0]  dim64;
  logic [31:0] w64;
  logic [6:0]  ones64;

  logic        start128, abort128, bf128, tb128, v128, l128, rdy128, busy128, done128;
  logic [6:0]  dim128;
  logic [31:0] w128;
  logic [7:0]  ones128;

  int           mode64;
  logic [127:0] p128;

  assign tb64  = (mode64 == 0) ? dim64[0] : (mode64 == 1);
  assign tb128 = p128[dim128];

  hv_bit_collector #(.HV_DIM(64), .WORD_W(32)) dut64 (
    .clk(clk), .rst(rst), .start(start64), .abort(abort64),
    .dim_idx(dim64), .bundling_features(bf64), .thresholded_bit(tb64),
    .hv_word(w64), .hv_word_valid(v64), .hv_word_last(l64), .hv_word_ready(rdy64),
    .ones_count(ones64), .busy(busy64), .done(done64)
  );

  hv_bit_collector #(.HV_DIM(128), .WORD_W(32)) dut128 (
    .clk(clk), .rst(rst), .start(start128), .abort(abort128),
    .dim_idx(dim128), .bundling_features(bf128), .thresholded_bit(tb128),
    .hv_word(w128), .hv_word_valid(v128), .hv_word_last(l128), .hv_word_ready(rdy128),
    .ones_count(ones128), .busy(busy128), .done(done128)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 64-dim run with ready held high; words and done timing are recorded for later checks.
  logic [31:0] wq[$];
  logic        lq[$];
  int          done_cyc, done_cnt;
  logic [5:0]  probe_dim1, probe_dim40;
  logic        probe_bf1;
  logic [6:0]  probe_ones10;

  task automatic run64(input int ncyc);
    wq.delete();
    lq.delete();
    done_cyc = -1;
    done_cnt = 0;
    rdy64    = 1'b1;
    start64  = 1'b1;
    tick();
    start64  = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      if (c == 1) begin
        probe_dim1 = dim64;
        probe_bf1  = bf64;
      end
      if (c == 10) probe_ones10 = ones64;
      if (c == 40) probe_dim40 = dim64;
      if (v64 && rdy64) begin
        wq.push_back(w64);
        lq.push_back(l64);
      end
      if (done64) begin
        done_cnt++;
        done_cyc = c;
      end
      tick();
    end
  endtask

  task automatic check_words64(input string tag, input logic [31:0] exp);
    check({tag, " nwords"}, 64'(wq.size()), 64'd2);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s word%0d", tag, i), (i < wq.size()) ? 64'(wq[i]) : 64'hBAD0BAD0, 64'(exp));
      check($sformatf("%s last%0d", tag, i), (i < lq.size()) ? 64'(lq[i]) : 64'hB, 64'(i == 1));
    end
  endtask

  // 128-dim golden model and collector.
  logic [31:0] g128 [4];
  int          pop128;
  int          nw128, err128, dn128;

  task automatic gold128();
    pop128 = 0;
    for (int w = 0; w < 4; w++) begin
      for (int b = 0; b < 32; b++) begin
        g128[w][b] = p128[w*32 + b];
        pop128 += int'(p128[w*32 + b]);
      end
    end
  endtask

  task automatic collect128(input int ncyc, input bit rnd);
    logic bad;
    nw128  = 0;
    err128 = 0;
    dn128  = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (rnd) rdy128 = 1'($urandom_range(0, 1));
      if (v128) begin
        bad = (nw128 >= 4);
        if (!bad) bad = (w128 !== g128[nw128]) || (l128 !== (nw128 == 3));
        if (bad) err128++;
        if (rdy128) nw128++;
      end
      if (done128) dn128++;
      tick();
    end
    rdy128 = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    start64 = 1'b0; abort64 = 1'b0; rdy64 = 1'b0; mode64 = 0;
    start128 = 1'b0; abort128 = 1'b0; rdy128 = 1'b0; p128 = '0;
    #12;
    check("reset outs64", {dim64, bf64, w64, v64, l64, ones64, busy64, done64}, 64'd0);
    check("reset outs128", {dim128, bf128, w128, v128, l128, ones128, busy128, done128}, 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Test 1: alternating bits
    mode64 = 0;
    run64(80);
    check_words64("t1", 32'hAAAAAAAA);
    check("t1 dim@c1", probe_dim1, 6'd0);
    check("t1 bf@c1", probe_bf1, 1'b1);
    check("t1 dim@c40", probe_dim40, 6'd39);
    check("t1 done cycle", done_cyc, 66);
    check("t1 done count", done_cnt, 1);
    check("t1 ones", ones64, 7'd32);
    check("t1 busy after", busy64, 1'b0);

    // Test 5: abort at dim 40 with the first word still buffered
    mode64 = 0;
    rdy64 = 1'b0;
    start64 = 1'b1;
    tick();
    start64 = 1'b0;
    for (int c = 1; c < 41; c++) tick();
    check("t5 dim before abort", dim64, 6'd40);
    check("t5 valid before abort", v64, 1'b1);
    abort64 = 1'b1;
    tick();
    abort64 = 1'b0;
    check("t5 busy after abort", busy64, 1'b0);
    check("t5 valid after abort", v64, 1'b0);
    done_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (done64) done_cnt++;
      tick();
    end
    check("t5 no done", done_cnt, 0);
    check("t5 ones held", ones64, 7'd32);
    run64(80);
    check("t5 restart dim", probe_dim1, 6'd0);
    check_words64("t5r", 32'hAAAAAAAA);
    check("t5r done cycle", done_cyc, 66);
    check("t5r ones", ones64, 7'd32);

    // Test 6: async reset during DRAIN, then a stray start mid-run
    mode64 = 0;
    rdy64 = 1'b0;
    start64 = 1'b1;
    tick();
    start64 = 1'b0;
    for (int c = 1; c < 70; c++) tick();
    check("t6 busy in drain", busy64, 1'b1);
    check("t6 word in drain", w64, 32'hAAAAAAAA);
    #1 rst = 1'b1;
    #1 check("t6 async reset outs", {dim64, bf64, w64, v64, l64, ones64, busy64, done64}, 64'd0);
    #1 rst = 1'b0;
    tick();
    rdy64 = 1'b1;
    start64 = 1'b1;
    tick();
    start64 = 1'b0;
    for (int c = 1; c < 19; c++) tick();
    check("t6 dim@c19", dim64, 6'd18);
    tick();
    start64 = 1'b1;
    tick();
    start64 = 1'b0;
    check("t6 dim@c21", dim64, 6'd20);
    tick();
    check("t6 dim@c22", dim64, 6'd21);
    done_cnt = 0;
    done_cyc = -1;
    for (int c = 22; c < 90; c++) begin
      if (done64) begin
        done_cnt++;
        done_cyc = c;
      end
      tick();
    end
    check("t6 done count", done_cnt, 1);
    check("t6 done cycle", done_cyc, 66);
    check("t6 ones", ones64, 7'd32);

    // Test 2: all ones, then all zeros
    mode64 = 1;
    run64(80);
    check("t2a ones during run", probe_ones10, 7'd32);
    check_words64("t2a", 32'hFFFFFFFF);
    check("t2a ones", ones64, 7'd64);
    check("t2a done count", done_cnt, 1);
    mode64 = 2;
    run64(80);
    check("t2b ones during run", probe_ones10, 7'd64);
    check_words64("t2b", 32'h00000000);
    check("t2b ones", ones64, 7'd0);
    check("t2b done count", done_cnt, 1);

    // Test 3: full backpressure on a 128-dim vector
    p128 = {$urandom, $urandom, $urandom, $urandom};
    gold128();
    rdy128 = 1'b0;
    start128 = 1'b1;
    tick();
    start128 = 1'b0;
    for (int c = 0; c < 150; c++) tick();
    check("t3 bf stalled", bf128, 1'b0);
    check("t3 dim held", dim128, 7'd95);
    check("t3 valid", v128, 1'b1);
    check("t3 head word", w128, g128[0]);
    for (int c = 0; c < 20; c++) tick();
    check("t3 dim still held", dim128, 7'd95);
    check("t3 head word stable", w128, g128[0]);
    rdy128 = 1'b1;
    collect128(200, 1'b0);
    check("t3 word errors", err128, 0);
    check("t3 nwords", nw128, 4);
    check("t3 done count", dn128, 1);
    check("t3 ones", ones128, 8'(pop128));

    // Test 4: random ready, random bits, 20 vectors
    for (int h = 0; h < 20; h++) begin
      p128 = {$urandom, $urandom, $urandom, $urandom};
      gold128();
      start128 = 1'b1;
      tick();
      start128 = 1'b0;
      collect128(600, 1'b1);
      check($sformatf("t4[%0d] word errors", h), err128, 0);
      check($sformatf("t4[%0d] nwords", h), nw128, 4);
      check($sformatf("t4[%0d] done count", h), dn128, 1);
      check($sformatf("t4[%0d] ones", h), ones128, 8'(pop128));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
